// File: rtl/mips_dbg_pkg.sv
// Shared types and constants for the MIPS debug readout blocks.
package mips_dbg_pkg;

  localparam int DM_WORD_BYTES = 4;
  localparam int RF_DEPTH      = 32;
  localparam int RF_ADDR_W     = $clog2(RF_DEPTH);
  localparam int BYTE_CNT_W    = $clog2(DM_WORD_BYTES);
  localparam int WORD_W        = 8 * DM_WORD_BYTES;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2,
    FINISH  = 2'd3
  } dump_state_e;

endpackage

// File: rtl/dump_word_assembler.sv
// Builds one 32-bit word from DataMemory bytes, MSB first, or loads a
// register-file word whole.
module dump_word_assembler
  import mips_dbg_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  shift_i,
  input  logic                  load_i,
  input  logic [7:0]            byte_i,
  input  logic [WORD_W-1:0]     word_i,
  output logic [WORD_W-1:0]     word_o,
  output logic [BYTE_CNT_W-1:0] byteCnt_o,
  output logic                  lastByte_o
);

  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(DM_WORD_BYTES - 1);

  logic [WORD_W-1:0]     word_q, word_d;
  logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;

  // The byte counter wraps naturally after the last byte, so it is already
  // zero when the next word's fetch begins.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      word_d = word_i;
    end else if (shift_i) begin
      word_d = {word_q[WORD_W-9:0], byte_i};
      cnt_d  = cnt_q + BYTE_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_o     = word_q;
  assign byteCnt_o  = cnt_q;
  assign lastByte_o = (cnt_q == LAST_BYTE);

endmodule

// File: rtl/mem_dump.sv
// Post-halt state readout: streams DataMemory words or register-file
// entries out over a valid/ready port.
module mem_dump
  import mips_dbg_pkg::*;
#(
  parameter int BYTE_ADDR_W = 10,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   sel_rf,
  input  logic [BYTE_ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]       num_words,
  output logic [BYTE_ADDR_W-1:0] mem_addr,
  input  logic [7:0]             mem_rdata,
  output logic [RF_ADDR_W-1:0]   rf_addr,
  input  logic [WORD_W-1:0]      rf_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_W-1:0]      out_data,
  output logic [CNT_W-1:0]       out_index,
  output logic                   busy,
  output logic                   done
);

  dump_state_e            state_q;
  logic                   selRf_q;
  logic [BYTE_ADDR_W-1:0] baseAddr_q;
  logic [CNT_W-1:0]       numWords_q;
  logic [CNT_W-1:0]       idx_q;

  logic                   asmClear, asmShift, asmLoad, lastByte;
  logic [BYTE_CNT_W-1:0]  byteCnt;
  logic [WORD_W-1:0]      word;

  assign asmClear = (state_q == IDLE) && start;
  assign asmShift = (state_q == FETCH) && !selRf_q;
  assign asmLoad  = (state_q == FETCH) && selRf_q;

  dump_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (asmClear),
    .shift_i    (asmShift),
    .load_i     (asmLoad),
    .byte_i     (mem_rdata),
    .word_i     (rf_rdata),
    .word_o     (word),
    .byteCnt_o  (byteCnt),
    .lastByte_o (lastByte)
  );

  // Read addresses are parked at zero outside a fetch; both wrap by width.
  assign mem_addr = asmShift
                  ? baseAddr_q + BYTE_ADDR_W'({idx_q, 2'b00}) + BYTE_ADDR_W'(byteCnt)
                  : '0;
  assign rf_addr  = asmLoad
                  ? baseAddr_q[RF_ADDR_W-1:0] + idx_q[RF_ADDR_W-1:0]
                  : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      selRf_q    <= 1'b0;
      baseAddr_q <= '0;
      numWords_q <= '0;
      idx_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            selRf_q    <= sel_rf;
            baseAddr_q <= base_addr;
            numWords_q <= num_words;
            idx_q      <= '0;
            state_q    <= (num_words == '0) ? FINISH : FETCH;
          end
        end
        FETCH: begin
          if (selRf_q || lastByte) state_q <= PRESENT;
        end
        PRESENT: begin
          if (out_ready) begin
            idx_q   <= idx_q + CNT_W'(1);
            state_q <= ((idx_q + CNT_W'(1)) == numWords_q) ? FINISH : FETCH;
          end
        end
        FINISH: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // The assembler holds its word through PRESENT, keeping data stable under backpressure.
  assign out_valid = (state_q == PRESENT);
  assign out_data  = word;
  assign out_index = idx_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINISH);

endmodule
